// File: rtl/spi_mcu_rx.sv
// SPI mode-0 slave receiver: oversamples mcu_sck/mcu_ce/mcu_sdi on fpga_sck and delivers WIDTH-bit MSB-first words.
// Latency: data_valid rises SYNC_STAGES+2 fpga_sck cycles after the mcu_sck edge carrying the last bit.
// Backpressure: none by default (single-cycle strobe); with SPI_RX_HOLD_EN data_valid holds until data_ack, newer words overwrite and set sticky overrun.
module spi_mcu_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             fpga_sck,
    input  logic             reset,
    input  logic             mcu_sck,
    input  logic             mcu_ce,
    input  logic             mcu_sdi,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, ce_sync, sdi_sync;
    logic                   sck_prev, ce_prev;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       shreg;
    logic                   extra;
    logic                   ce_gone;

    logic          sck_s, ce_s, sdi_s;
    logic          sck_rise, ce_rise, ce_fall;
    logic [CW-1:0] cnt_nxt;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ce_s     = ce_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign ce_rise  = ce_s & ~ce_prev;
    assign ce_fall  = ~ce_s & ce_prev;
    assign cnt_nxt  = sck_rise ? cnt + CW'(1) : cnt;

    always_ff @(posedge fpga_sck) begin
        if (reset) begin
            sck_sync <= '0;
            ce_sync  <= '0;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
            ce_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], mcu_sck};
            ce_sync  <= {ce_sync[SYNC_STAGES-2:0], mcu_ce};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], mcu_sdi};
            sck_prev <= sck_s;
            ce_prev  <= ce_s;
        end
    end

`ifndef SPI_RX_HOLD_EN
    logic unused_ack;
    assign unused_ack = data_ack;
`endif

    always_ff @(posedge fpga_sck) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            extra      <= 1'b0;
            ce_gone    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
`ifdef SPI_RX_HOLD_EN
            if (data_ack && data_valid)
                data_valid <= 1'b0;
`else
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (ce_rise) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        shreg   <= '0;
                        extra   <= 1'b0;
                        ce_gone <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sck_rise && cnt != FULL) begin
                        shreg <= {shreg[WIDTH-2:0], sdi_s};
                        cnt   <= cnt_nxt;
                    end
                    if (cnt == FULL) begin
                        // Word captured on the previous cycle; deliver it now.
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                        extra      <= sck_rise;
`ifdef SPI_RX_HOLD_EN
                        if (data_valid && !data_ack)
                            overrun <= 1'b1;
`endif
                        if (ce_fall || ce_gone) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= sck_rise;
                        end else begin
                            state <= DONE;
                        end
                    end else if (ce_fall) begin
                        if (cnt_nxt < FULL) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            ce_gone <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sck_rise)
                        extra <= 1'b1;
                    if (ce_fall) begin
                        frame_err <= extra | sck_rise;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mcu_rx.sv
// Directed bench for spi_mcu_rx: frames driven with mcu_sck at fpga_sck/8, outputs sampled on the falling edge.
module tb_spi_mcu_rx;

    logic        fpga_sck = 1'b0;
    logic        reset    = 1'b1;
    logic        mcu_sck  = 1'b0;
    logic        mcu_ce   = 1'b0;
    logic        mcu_sdi  = 1'b0;
    logic        data_ack = 1'b0;
    logic [15:0] data_out;
    logic        data_valid, busy, frame_err, overrun;

    spi_mcu_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .fpga_sck   (fpga_sck),
        .reset      (reset),
        .mcu_sck    (mcu_sck),
        .mcu_ce     (mcu_ce),
        .mcu_sdi    (mcu_sdi),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 fpga_sck = ~fpga_sck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_cyc = 0;
    bit auto_ack = 1'b1;

    // Monitor: counts rising edges and high cycles of data_valid / frame_err.
    int          vcount = 0, vhi = 0, ecount = 0, ehi = 0, last_vcyc = 0;
    logic        dv_prev = 1'b0, fe_prev = 1'b0;
    logic [15:0] vals[$];

    always @(posedge fpga_sck) cyc <= cyc + 1;

    always @(negedge fpga_sck) begin
        if (data_valid && !dv_prev) begin
            vcount++;
            vals.push_back(data_out);
            last_vcyc = cyc;
        end
        if (data_valid) vhi++;
        if (frame_err && !fe_prev) ecount++;
        if (frame_err) ehi++;
        dv_prev = data_valid;
        fe_prev = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge fpga_sck);
        #1;
    endtask

    task automatic frame_start;
        mcu_ce = 1'b1;
        cycles(4);
    endtask

    task automatic send_bit(input logic b);
        mcu_sdi = b;
        cycles(4);
        mcu_sck  = 1'b1;
        rise_cyc = cyc;
        cycles(4);
        mcu_sck = 1'b0;
    endtask

    task automatic frame_end(input int gap);
        cycles(4);
        mcu_ce = 1'b0;
        if (auto_ack) begin
            data_ack = 1'b1;
            cycles(1);
            data_ack = 1'b0;
        end
        cycles(gap);
    endtask

    task automatic send_frame(input logic [31:0] data, input int n, input int gap);
        frame_start();
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(data[i]);
            if (i == n - 1) chk("busy_in_frame", busy, 1);
        end
        frame_end(gap);
    endtask

    int v0, e0;

    initial begin
        cycles(3);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        cycles(2);

        // Full 16-bit frame
        v0 = vcount; e0 = ecount;
        send_frame(32'hA5C3, 16, 8);
        chk("a5c3_valid_cnt", vcount - v0, 1);
        chk("a5c3_value", vals[vals.size()-1], 16'hA5C3);
        chk("a5c3_latency", last_vcyc - rise_cyc, 4);
        chk("a5c3_no_ferr", ecount - e0, 0);
        chk("a5c3_data_out", data_out, 16'hA5C3);
        chk("a5c3_idle_busy", busy, 0);

        // Short frame: 9 bits then ce drops
        v0 = vcount; e0 = ecount;
        send_frame(32'h1FF, 9, 8);
        chk("short_ferr_cnt", ecount - e0, 1);
        chk("short_no_valid", vcount - v0, 0);
        chk("short_hold_data", data_out, 16'hA5C3);

        // 18 clocks: 0x1234 followed by two extra bits
        v0 = vcount; e0 = ecount;
        send_frame(32'h48D2, 18, 8);
        chk("long_valid_cnt", vcount - v0, 1);
        chk("long_value", vals[vals.size()-1], 16'h1234);
        chk("long_ferr_cnt", ecount - e0, 1);

        // Back-to-back frames with a 2-cycle ce gap
        v0 = vcount; e0 = ecount;
        send_frame(32'h0001, 16, 2);
        send_frame(32'h8000, 16, 8);
        chk("b2b_valid_cnt", vcount - v0, 2);
        chk("b2b_first", vals[vals.size()-2], 16'h0001);
        chk("b2b_second", vals[vals.size()-1], 16'h8000);
        chk("b2b_no_ferr", ecount - e0, 0);

        // Reset in the middle of a frame
        v0 = vcount; e0 = ecount;
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        reset = 1'b1;
        cycles(1);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_busy", busy, 0);
        mcu_ce = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(6);
        chk("midrst_no_ferr", ecount - e0, 0);
        chk("midrst_no_valid", vcount - v0, 0);
        send_frame(32'hBEEF, 16, 8);
        chk("beef_valid_cnt", vcount - v0, 1);
        chk("beef_value", vals[vals.size()-1], 16'hBEEF);
        chk("beef_data_out", data_out, 16'hBEEF);

`ifdef SPI_RX_HOLD_EN
        // Handshake: two words without ack -> overwrite and overrun
        auto_ack = 1'b0;
        send_frame(32'h1111, 16, 8);
        chk("hold_valid_level", data_valid, 1);
        chk("hold_no_overrun", overrun, 0);
        send_frame(32'h2222, 16, 8);
        chk("hold_overwrite", data_out, 16'h2222);
        chk("hold_valid_still", data_valid, 1);
        chk("hold_overrun", overrun, 1);
        data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
        chk("hold_ack_clears", data_valid, 0);
        chk("hold_overrun_sticky", overrun, 1);
`else
        chk("dv_pulse_width", vhi, vcount);
        data_ack = 1'b1;
        cycles(2);
        data_ack = 1'b0;
        chk("overrun_tied", overrun, 0);
`endif
        chk("ferr_pulse_width", ehi, ecount);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mcu_rx.md
Name: spi_mcu_rx

Overview:
- SPI slave receiver for MCU-to-FPGA traffic. It is the opposite direction of the FPGA-to-MCU transmit shift register.
- The MCU is SPI master and drives mcu_sck, mcu_ce and mcu_sdi.
- The block oversamples all three on the single FPGA clock, shifts in WIDTH bits MSB-first (SPI mode 0), and presents each completed word to FPGA logic with a valid strobe and a framing-error indication.

Parameters:
- WIDTH, 16, bits per frame (≥2).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2).

Ports:
- fpga_sck  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- mcu_sck  input  1  SPI clock from MCU; asynchronous to fpga_sck.
- mcu_ce  input  1  chip enable from MCU, active-high, frames a transfer.
- mcu_sdi  input  1  serial data from MCU (MOSI).
- data_ack  input  1  consumer acknowledge; used only with SPI_RX_HOLD_EN.
- data_out  output  WIDTH  last completed word.
- data_valid  output  1  completed-word strobe/flag.
- busy  output  1  high while a frame is in progress.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- overrun  output  1  sticky; used only with SPI_RX_HOLD_EN, otherwise tied 0.

Behaviour:
- Reset (synchronous, active-high):
  - All synchronizer flops clear to 0; edge-history registers clear to 0.
  - State=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
  - Reset asserted mid-frame aborts the frame silently: no frame_err, and data_out returns to 0.
- Synchronization:
  - mcu_sck, mcu_ce and mcu_sdi each pass through SYNC_STAGES flops.
  - sck_rise is detected when the synced sck is 1 and the previous synced sck was 0.
  - ce_rise and ce_fall are detected the same way.
  - mcu_sdi passes through the identical path, so the sampled bit is aligned to sck_rise.
- Timing requirement: each mcu_sck high and low phase ≥ SYNC_STAGES+1 fpga_sck periods. mcu_ce setup and hold to the first and last mcu_sck edge ≥ 1 mcu_sck half-period.
- IDLE:
  - busy=0.
  - On ce_rise: go to SHIFT, clear counter and shift register.
  - sck edges while ce is low are ignored.
- SHIFT:
  - busy=1.
  - On sck_rise: shreg ← {shreg[WIDTH-2:0], sdi_sync}; counter increments.
  - When the WIDTH-th bit is captured, in the cycle after that sck_rise:
    - data_out ← completed word;
    - data_valid=1;
    - go to DONE.
  - On ce_fall with counter < WIDTH: frame_err pulses 1 cycle, data_out is unchanged, go to IDLE.
  - If sck_rise and ce_fall occur in the same cycle, the bit is captured first, then the ce_fall rule is evaluated on the new count.
- DONE:
  - busy=1.
  - Further sck_rise in the same frame: word already delivered is kept, extra bits are discarded, and a flag is set.
  - On ce_fall: go to IDLE. frame_err pulses 1 cycle if extra bits were seen.
- Latency: data_valid is asserted SYNC_STAGES+2 fpga_sck cycles after the mcu_sck edge that carries the last bit.
- Back-to-back frames: ce_fall and ce_rise of the next frame may be as close as 2 fpga_sck cycles. A ce_rise while already in SHIFT/DONE cannot occur (it requires a prior ce_fall).

Optional Feature:
- Macro: SPI_RX_HOLD_EN.
- Defined (handshake mode):
  - data_valid is a level. It sets on word completion and clears in the cycle after data_ack=1 is sampled.
  - If a new word completes while data_valid=1: data_out is overwritten with the new word, data_valid stays 1, and overrun sets.
  - overrun is sticky until reset.
  - data_ack while data_valid=0 is ignored.
  - Completion and data_ack in the same cycle: the completion wins, data_valid stays 1, and no overrun is flagged.
- Undefined:
  - data_valid is a single-cycle pulse; data_ack is ignored; overrun is constant 0.

Test Plan:
- Reset, then a 16-bit frame 0xA5C3 MSB-first with mcu_sck at fpga_sck/8 -> data_out=0xA5C3, exactly one data_valid pulse at the expected latency, busy high for the frame, frame_err=0.
- ce drops after 9 bits of 0xFFFF -> frame_err 1-cycle pulse, data_out holds the previous 0xA5C3, no data_valid.
- 18 clocks in one frame, data 0x1234 followed by 2 extra bits -> data_valid once with 0x1234, frame_err pulse at ce_fall.
- Two frames 0x0001 then 0x8000 separated by a 2-cycle ce gap -> two data_valid events with those values in order.
- Reset asserted after 8 bits, then a full frame 0xBEEF -> no frame_err on the aborted frame, data_out=0 during reset, then 0xBEEF.
- With SPI_RX_HOLD_EN: frame 0x1111 with no ack, then 0x2222 -> data_out=0x2222, overrun=1; data_ack then clears data_valid the next cycle while overrun stays 1.
